// File: rtl/rv_mc_controller.sv
// rv_mc_controller: multi-cycle RV32I control FSM with handshaked memory port, timeout and illegal-instruction trap
module rv_mc_controller #(
  parameter int MEM_TIMEOUT   = 16,
  parameter bit ILLEGAL_TRAP  = 1'b1,
  parameter bit SUPPORT_FENCE = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        Mem_Read,
  output logic [2:0]  Mem_OP,
  output logic        ir_write,
  output logic        pc_write,
  output logic [2:0]  Branch,
  output logic [3:0]  ALU_OP,
  output logic [2:0]  ALU_SRC,
  output logic [2:0]  IMM_OP,
  output logic        Reg_Write,
  output logic        Mem_to_Reg,
  output logic        illegal,
  output logic        bus_err
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] LIM = CW'(MEM_TIMEOUT - 1);
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LUI = 7'b0110111,
    OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111, OP_BR = 7'b1100011,
    OP_LD = 7'b0000011, OP_ST = 7'b0100011, OP_FENCE = 7'b0001111;
  state_t state;
  logic [CW-1:0] cnt;
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic legal, is_ld, is_st, is_br, is_fence, held;
  logic [3:0] d_alu;
  logic [2:0] d_src, d_imm, d_br;
  logic unused_fields;
  assign op = inst[6:0];
  assign f3 = inst[14:12];
  assign f7 = inst[31:25];
  assign unused_fields = ^{inst[24:15], inst[11:7]};
  // Decoded fields are forced to zero for illegal words so a NOP-retired instruction drives nothing.
  always_comb begin
    legal = 1'b1;
    d_alu = 4'b0000;
    d_src = 3'b000;
    d_imm = 3'b000;
    d_br  = 3'b000;
    case (op)
      OP_R: begin
        legal = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
        d_alu = {f7[5], f3};
      end
      OP_I: begin
        legal = f3 == 3'b001 ? f7 == 7'h00 : f3 == 3'b101 ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
        d_alu = {f3 == 3'b101 && f7[5], f3};
        d_src = 3'b010;
        d_imm = 3'b001;
      end
      OP_LUI: begin
        d_alu = 4'b0011;
        d_src = 3'b010;
        d_imm = 3'b010;
      end
      OP_AUIPC: begin
        d_src = 3'b011;
        d_imm = 3'b010;
      end
      OP_JAL: begin
        d_src = 3'b101;
        d_imm = 3'b101;
        d_br  = 3'b001;
      end
      OP_JALR: begin
        legal = f3 == 3'b000;
        d_src = 3'b101;
        d_imm = 3'b001;
        d_br  = 3'b010;
      end
      OP_BR: begin
        legal = f3[2:1] != 2'b01;
        d_alu = f3[2:1] == 2'b11 ? 4'b1010 : 4'b1000;
        d_imm = 3'b100;
        d_br  = {1'b1, f3[2], f3[0]};
      end
      OP_LD: begin
        legal = f3 != 3'b011 && f3[2:1] != 2'b11;
        d_src = 3'b010;
        d_imm = 3'b001;
      end
      OP_ST: begin
        legal = f3 < 3'b011;
        d_src = 3'b010;
        d_imm = 3'b011;
      end
      OP_FENCE: legal = SUPPORT_FENCE;
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      d_alu = 4'b0000;
      d_src = 3'b000;
      d_imm = 3'b000;
      d_br  = 3'b000;
    end
  end
  assign is_ld    = legal && op == OP_LD;
  assign is_st    = legal && op == OP_ST;
  assign is_br    = legal && op == OP_BR;
  assign is_fence = legal && op == OP_FENCE;
  assign held     = state == EXEC || state == MEM || state == WB;
  assign mem_req      = state == FETCH || state == MEM;
  assign mem_addr_sel = state == MEM;
  assign mem_we       = state == MEM && is_st;
  assign Mem_Read     = state == MEM && is_ld;
  assign Mem_OP       = state == MEM ? f3 : 3'b000;
  assign ir_write     = state == FETCH && mem_ack;
  assign pc_write     = (state == EXEC && is_br) || (state == MEM && is_st && mem_ack) || state == WB;
  assign Branch       = held ? d_br : 3'b000;
  assign ALU_OP       = held ? d_alu : 4'b0000;
  assign ALU_SRC      = held ? d_src : 3'b000;
  assign IMM_OP       = (held || state == DECODE) ? d_imm : 3'b000;
  assign Reg_Write    = state == WB && legal && !is_fence;
  assign Mem_to_Reg   = state == WB && is_ld;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      illegal <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      cnt <= (mem_req && !mem_ack) ? cnt + 1'b1 : '0;
      case (state)
        IDLE: state <= FETCH;
        FETCH, MEM:
          if (mem_ack) state <= (state == FETCH) ? DECODE : (is_ld ? WB : FETCH);
          else if (cnt == LIM) begin
            state   <= TRAP;
            bus_err <= 1'b1;
          end
        DECODE:
          if (legal) state <= EXEC;
          else if (ILLEGAL_TRAP) begin
            state   <= TRAP;
            illegal <= 1'b1;
          end else state <= WB;
        EXEC: state <= is_br ? FETCH : (is_ld || is_st) ? MEM : WB;
        WB: state <= FETCH;
        default: state <= state;
      endcase
    end
  end
endmodule

// File: tb/tb_rv_mc_controller.sv
// tb_rv_mc_controller: two controller instances (trapping/timeout-8 and NOP-retiring/no-FENCE) checked cycle by cycle
module tb_rv_mc_controller;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n [2];
  logic mem_ack [2];
  logic [31:0] inst [2];
  logic [23:0] ov [2];
  logic [1:0] fl [2];
  int checks = 0, failures = 0;

  for (genvar k = 0; k < 2; k++) begin : g
    logic mem_req, mem_we, mem_addr_sel, Mem_Read, ir_write, pc_write, Reg_Write, Mem_to_Reg, illegal, bus_err;
    logic [2:0] Mem_OP, Branch, ALU_SRC, IMM_OP;
    logic [3:0] ALU_OP;
    rv_mc_controller #(.MEM_TIMEOUT(k == 0 ? 8 : 16), .ILLEGAL_TRAP(k == 0), .SUPPORT_FENCE(k == 0)) dut (
      .clk(clk), .rst_n(rst_n[k]), .inst(inst[k]), .mem_ack(mem_ack[k]),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .Mem_Read(Mem_Read),
      .Mem_OP(Mem_OP), .ir_write(ir_write), .pc_write(pc_write), .Branch(Branch), .ALU_OP(ALU_OP),
      .ALU_SRC(ALU_SRC), .IMM_OP(IMM_OP), .Reg_Write(Reg_Write), .Mem_to_Reg(Mem_to_Reg),
      .illegal(illegal), .bus_err(bus_err));
    assign ov[k] = {mem_req, mem_we, mem_addr_sel, Mem_Read, Mem_OP, ir_write, pc_write, Branch,
                    ALU_OP, ALU_SRC, IMM_OP, Reg_Write, Mem_to_Reg};
    assign fl[k] = {illegal, bus_err};
  end

  typedef struct packed {
    logic legal, br, ld, st, fence;
    logic [3:0] alu;
    logic [2:0] src, imm, brc;
  } dec_t;
  typedef struct packed { logic ack; logic [23:0] v; } cyc_t;
  typedef struct packed { logic [31:0] w; logic [3:0] fw, mw; } job_t;

  function automatic logic [23:0] pv(input logic req, we, asel, rd, input logic [2:0] mop,
    input logic irw, pcw, input logic [2:0] br, input logic [3:0] alu, input logic [2:0] src, imm,
    input logic rw, m2r);
    return {req, we, asel, rd, mop, irw, pcw, br, alu, src, imm, rw, m2r};
  endfunction

  // Instruction-class view of the ISA: what each class asks of the datapath.
  function automatic dec_t ref_dec(input logic [31:0] w, input logic fence_ok);
    dec_t r;
    logic [2:0] f3;
    logic [6:0] f7;
    r = '0;
    f3 = w[14:12];
    f7 = w[31:25];
    case (w[6:0])
      7'b0110011: begin
        r.legal = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        r.alu = 4'(f3) + (f7 == 7'h20 ? 4'd8 : 4'd0);
      end
      7'b0010011: begin
        r.legal = (f3 == 3'd1) ? f7 == 7'h00 : (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
        r.alu = 4'(f3) + ((f3 == 3'd5 && f7 == 7'h20) ? 4'd8 : 4'd0);
        r.src = 3'b010; r.imm = 3'b001;
      end
      7'b0110111: begin r.legal = 1'b1; r.alu = 4'd3; r.src = 3'b010; r.imm = 3'b010; end
      7'b0010111: begin r.legal = 1'b1; r.src = 3'b011; r.imm = 3'b010; end
      7'b1101111: begin r.legal = 1'b1; r.src = 3'b101; r.imm = 3'b101; r.brc = 3'b001; end
      7'b1100111: begin r.legal = f3 == 3'd0; r.src = 3'b101; r.imm = 3'b001; r.brc = 3'b010; end
      7'b1100011: begin
        r.legal = f3 != 3'd2 && f3 != 3'd3; r.br = 1'b1; r.imm = 3'b100;
        r.alu = f3 >= 3'd6 ? 4'b1010 : 4'b1000;
        r.brc = f3 == 3'd0 ? 3'b100 : f3 == 3'd1 ? 3'b101 : (f3 == 3'd4 || f3 == 3'd6) ? 3'b110 : 3'b111;
      end
      7'b0000011: begin r.legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}; r.ld = 1'b1; r.src = 3'b010; r.imm = 3'b001; end
      7'b0100011: begin r.legal = f3 <= 3'd2; r.st = 1'b1; r.src = 3'b010; r.imm = 3'b011; end
      7'b0001111: begin r.legal = fence_ok; r.fence = 1'b1; end
      default: ;
    endcase
    return r.legal ? r : '0;
  endfunction

  function automatic logic [31:0] gen_word(input logic legal_only, input logic fence_ok);
    logic [31:0] w;
    dec_t r;
    for (int t = 0; t < 64; t++) begin
      w = $urandom;
      case ($urandom_range(11))
        0: w[6:0] = 7'b0110011;  1: w[6:0] = 7'b0010011;  2: w[6:0] = 7'b0110111;
        3: w[6:0] = 7'b0010111;  4: w[6:0] = 7'b1101111;  5: w[6:0] = 7'b1100111;
        6: w[6:0] = 7'b1100011;  7: w[6:0] = 7'b0000011;  8: w[6:0] = 7'b0100011;
        9: w[6:0] = 7'b0001111; 10: w[6:0] = 7'b1110011;
        default: ;
      endcase
      if ($urandom_range(2) == 0) w[31:25] = 7'h00;
      else if ($urandom_range(1) == 0) w[31:25] = 7'h20;
      r = ref_dec(w, fence_ok);
      if (!legal_only || r.legal) return w;
    end
    return 32'h00000013;
  endfunction

  task automatic tick(input int d, input logic ack, input logic [31:0] w);
    @(posedge clk);
    #1 mem_ack[d] = ack;
    inst[d] = w;
    @(negedge clk);
  endtask

  task automatic do_reset(input int d);
    @(posedge clk);
    #1 rst_n[d] = 1'b0;
    mem_ack[d] = 1'b0;
    @(posedge clk);
    #1 rst_n[d] = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset(0);
    checks++;
    if (ov[0] !== 24'h0 || fl[0] !== 2'b00) begin
      failures++; $display("FAIL reset_idle got=%h/%b exp=000000/00", ov[0], fl[0]);
    end
    rst_n[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick(0, 1'b1, 32'h002081B3);
      checks++;
      if (ov[0] !== 24'h0) begin failures++; $display("FAIL reset_hold got=%h exp=000000", ov[0]); end
    end
    rst_n[0] = 1'b1;
    tick(0, 1'b0, 32'h002081B3);
    checks++;
    if (ov[0] !== pv(1,0,0,0,0,0,0,0,0,0,0,0,0)) begin
      failures++; $display("FAIL reset_to_fetch got=%h exp=%h", ov[0], pv(1,0,0,0,0,0,0,0,0,0,0,0,0));
    end
    tick(0, 1'b1, 32'h002081B3);
    checks++;
    if (ov[0] !== pv(1,0,0,0,0,1,0,0,0,0,0,0,0)) begin
      failures++; $display("FAIL fetch_ack_irw got=%h exp=%h", ov[0], pv(1,0,0,0,0,1,0,0,0,0,0,0,0));
    end
  endtask

  task automatic test_program(input int d, input int n);
    job_t jobs[$];
    cyc_t q[$];
    dec_t r;
    logic [31:0] w;
    logic [2:0] f3;
    if (d == 0) begin
      jobs = '{{32'h002081B3, 4'd0, 4'd0}, {32'h0040A283, 4'd0, 4'd2}, {32'h00000463, 4'd0, 4'd0},
               {32'h00208023, 4'd1, 4'd0}, {32'h0000000F, 4'd0, 4'd0}, {32'h008000EF, 4'd2, 4'd0},
               {32'h00008067, 4'd0, 4'd0}, {32'h12345037, 4'd0, 4'd0}, {32'h00001097, 4'd0, 4'd0},
               {32'h4020D193, 4'd0, 4'd0}, {32'h40208233, 4'd7, 4'd0}, {32'h0040A283, 4'd7, 4'd7}};
    end else begin
      jobs = '{{32'hFFFFFFFF, 4'd0, 4'd0}, {32'h0000000F, 4'd1, 4'd0}, {32'h00000073, 4'd0, 4'd0},
               {32'h02208033, 4'd0, 4'd0}, {32'h002081B3, 4'd0, 4'd0}, {32'h0040A283, 4'd1, 4'd1}};
    end
    for (int j = 0; j < n; j++)
      jobs.push_back({gen_word(d == 0, d == 0), 4'($urandom_range(3)), 4'($urandom_range(3))});
    do_reset(d);
    foreach (jobs[j]) begin
      w = jobs[j].w;
      f3 = w[14:12];
      r = ref_dec(w, d == 0);
      q.delete();
      for (int i = 0; i < int'(jobs[j].fw); i++) q.push_back({1'b0, pv(1,0,0,0,0,0,0,0,0,0,0,0,0)});
      q.push_back({1'b1, pv(1,0,0,0,0,1,0,0,0,0,0,0,0)});
      if (!r.legal) begin
        q.push_back({1'b0, 24'h0});
        q.push_back({1'b0, pv(0,0,0,0,0,0,1,0,0,0,0,0,0)});
      end else begin
        q.push_back({1'b0, pv(0,0,0,0,0,0,0,0,0,0,r.imm,0,0)});
        q.push_back({1'b0, pv(0,0,0,0,0,0,r.br,r.brc,r.alu,r.src,r.imm,0,0)});
        if (r.ld || r.st) begin
          for (int i = 0; i < int'(jobs[j].mw); i++)
            q.push_back({1'b0, pv(1,r.st,1,r.ld,f3,0,0,r.brc,r.alu,r.src,r.imm,0,0)});
          q.push_back({1'b1, pv(1,r.st,1,r.ld,f3,0,r.st,r.brc,r.alu,r.src,r.imm,0,0)});
        end
        if (!r.br && !r.st) q.push_back({1'b0, pv(0,0,0,0,0,0,1,r.brc,r.alu,r.src,r.imm,!r.fence,r.ld)});
      end
      foreach (q[i]) begin
        tick(d, q[i].ack, w);
        checks++;
        if (ov[d] !== q[i].v || fl[d] !== 2'b00) begin
          failures++;
          $display("FAIL program dut%0d inst=%h cyc=%0d got=%h/%b exp=%h/00", d, w, i, ov[d], fl[d], q[i].v);
        end
      end
    end
  endtask

  task automatic test_illegal_trap();
    do_reset(0);
    tick(0, 1'b1, 32'hFFFFFFFF);
    checks++;
    if (ov[0] !== pv(1,0,0,0,0,1,0,0,0,0,0,0,0)) begin failures++; $display("FAIL trap_fetch got=%h", ov[0]); end
    tick(0, 1'b0, 32'hFFFFFFFF);
    for (int i = 0; i < 4; i++) begin
      tick(0, i[0], 32'hFFFFFFFF);
      checks++;
      if (ov[0] !== 24'h0 || fl[0] !== 2'b10) begin
        failures++; $display("FAIL trap_hold cyc=%0d got=%h/%b exp=000000/10", i, ov[0], fl[0]);
      end
    end
    do_reset(0);
    checks++;
    if (fl[0] !== 2'b00) begin failures++; $display("FAIL trap_reset_flags got=%b exp=00", fl[0]); end
  endtask

  task automatic test_timeout();
    do_reset(0);
    for (int i = 0; i < 8; i++) begin
      tick(0, 1'b0, 32'h0040A283);
      checks++;
      if (ov[0] !== pv(1,0,0,0,0,0,0,0,0,0,0,0,0) || fl[0] !== 2'b00) begin
        failures++; $display("FAIL fetch_wait cyc=%0d got=%h/%b", i, ov[0], fl[0]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      tick(0, 1'b1, 32'h0040A283);
      checks++;
      if (ov[0] !== 24'h0 || fl[0] !== 2'b01) begin
        failures++; $display("FAIL fetch_timeout got=%h/%b exp=000000/01", ov[0], fl[0]);
      end
    end
    do_reset(0);
    tick(0, 1'b1, 32'h0040A283);
    tick(0, 1'b0, 32'h0040A283);
    tick(0, 1'b0, 32'h0040A283);
    for (int i = 0; i < 8; i++) begin
      tick(0, 1'b0, 32'h0040A283);
      checks++;
      if (ov[0] !== pv(1,0,1,1,3'b010,0,0,0,0,3'b010,3'b001,0,0) || fl[0] !== 2'b00) begin
        failures++; $display("FAIL mem_wait cyc=%0d got=%h/%b", i, ov[0], fl[0]);
      end
    end
    tick(0, 1'b0, 32'h0040A283);
    checks++;
    if (ov[0] !== 24'h0 || fl[0] !== 2'b01) begin
      failures++; $display("FAIL mem_timeout got=%h/%b exp=000000/01", ov[0], fl[0]);
    end
  endtask

  task automatic test_reset_mid_mem();
    do_reset(0);
    tick(0, 1'b1, 32'h00208023);
    tick(0, 1'b0, 32'h00208023);
    tick(0, 1'b0, 32'h00208023);
    tick(0, 1'b0, 32'h00208023);
    checks++;
    if (ov[0] !== pv(1,1,1,0,3'b000,0,0,0,0,3'b010,3'b011,0,0)) begin
      failures++; $display("FAIL store_mem got=%h", ov[0]);
    end
    rst_n[0] = 1'b0;
    tick(0, 1'b1, 32'h00208023);
    checks++;
    if (ov[0] !== 24'h0 || fl[0] !== 2'b00) begin
      failures++; $display("FAIL midmem_reset got=%h/%b exp=000000/00", ov[0], fl[0]);
    end
    rst_n[0] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick(0, 1'b0, 32'h00208023);
      checks++;
      if (ov[0] !== pv(1,0,0,0,0,0,0,0,0,0,0,0,0)) begin
        failures++; $display("FAIL midmem_refetch cyc=%0d got=%h", i, ov[0]);
      end
    end
  endtask

  initial begin
    rst_n = '{1'b0, 1'b0};
    mem_ack = '{1'b0, 1'b0};
    inst = '{32'h0, 32'h0};
    test_reset();
    test_program(0, 40);
    test_illegal_trap();
    test_timeout();
    test_reset_mid_mem();
    test_program(1, 40);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule
